// File: rtl/key_cursor_ctrl.sv
// -----------------------------------------------------------------------------
// key_cursor_ctrl
//   Turns keyboard make/break events into cursor movement on a COLS x ROWS
//   board, with optional auto-repeat of a held direction key and one-cycle
//   action pulses for Space, G and Esc.
//
// Ports
//   clk          : single clock
//   rstn         : asynchronous active-low reset
//   key_event    : [10] valid, [9] E0-extended, [8] break, [7:0] scancode
//   cursor_x     : current column (0..COLS-1)
//   cursor_y     : current row    (0..ROWS-1)
//   sel_pulse    : one cycle, Space pressed
//   aux_pulse    : one cycle, G pressed
//   cancel_pulse : one cycle, Esc pressed
//   move_pulse   : one cycle, cursor changed position
//   bump_pulse   : one cycle, a step was blocked at a board edge (clamp mode)
// -----------------------------------------------------------------------------
module key_cursor_ctrl #(
  parameter int COLS       = 8,
  parameter int ROWS       = 8,
  parameter int XW         = 3,
  parameter int YW         = 3,
  parameter int WRAP       = 1,
  parameter int REPEAT_EN  = 1,
  parameter int REP_DELAY  = 25000000,
  parameter int REP_PERIOD = 5000000,
  parameter int CW         = 26
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [10:0]   key_event,
  output logic [XW-1:0] cursor_x,
  output logic [YW-1:0] cursor_y,
  output logic          sel_pulse,
  output logic          aux_pulse,
  output logic          cancel_pulse,
  output logic          move_pulse,
  output logic          bump_pulse
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  localparam logic [8:0] CODE_SPACE = 9'h029;
  localparam logic [8:0] CODE_G     = 9'h034;
  localparam logic [8:0] CODE_ESC   = 9'h076;

  // Direction decode: bit 2 = is a direction key, [1:0] = 0 up, 1 down,
  // 2 left, 3 right.
  function automatic logic [2:0] dir_decode(input logic [8:0] code);
    case (code)
      9'h01D, 9'h043, 9'h175: dir_decode = 3'b100;
      9'h01B, 9'h042, 9'h172: dir_decode = 3'b101;
      9'h01C, 9'h03B, 9'h16B: dir_decode = 3'b110;
      9'h023, 9'h04B, 9'h174: dir_decode = 3'b111;
      default:                dir_decode = 3'b000;
    endcase
  endfunction

  state_t        state_r;
  logic [8:0]    held_code_r;
  logic [CW-1:0] cnt_r;

  logic [8:0]    code_s;
  logic          new_make_s;
  logic          held_break_s;
  logic [2:0]    make_dir_s;
  logic [2:0]    held_dir_s;
  logic          rep_due_s;
  logic          step_s;
  logic [1:0]    step_dir_s;
  logic [XW-1:0] next_x_s;
  logic [YW-1:0] next_y_s;
  logic          blocked_s;

  assign code_s       = {key_event[9], key_event[7:0]};
  // A level-held event repeats the held code, so it is never a new make.
  assign new_make_s   = key_event[10] & ~key_event[8] & (code_s != held_code_r);
  assign held_break_s = key_event[10] &  key_event[8] & (code_s == held_code_r);
  assign make_dir_s   = dir_decode(code_s);
  assign held_dir_s   = dir_decode(held_code_r);

  // Repeat timer expiry in the current state, taken from the held key.
  always_comb begin
    rep_due_s = 1'b0;
    if (held_dir_s[2]) begin
      if ((state_r == ST_DELAY) && (cnt_r == CW'(REP_DELAY - 1))) begin
        rep_due_s = 1'b1;
      end else if ((state_r == ST_REPEAT) && (cnt_r == CW'(REP_PERIOD - 1))) begin
        rep_due_s = 1'b1;
      end else begin
        rep_due_s = 1'b0;
      end
    end else begin
      rep_due_s = 1'b0;
    end
  end

  // Pick at most one step per cycle; a new make or a held-key break
  // suppresses any repeat step due in the same cycle.
  always_comb begin
    step_s     = 1'b0;
    step_dir_s = 2'b00;
    if (new_make_s && make_dir_s[2]) begin
      step_s     = 1'b1;
      step_dir_s = make_dir_s[1:0];
    end else if (!new_make_s && !held_break_s && rep_due_s) begin
      step_s     = 1'b1;
      step_dir_s = held_dir_s[1:0];
    end else begin
      step_s     = 1'b0;
      step_dir_s = 2'b00;
    end
  end

  // Next position for the selected direction; edge tests use >= so an
  // out-of-range coordinate can never be incremented further.
  always_comb begin
    next_x_s  = cursor_x;
    next_y_s  = cursor_y;
    blocked_s = 1'b0;
    case (step_dir_s)
      2'b00: begin
        if (cursor_y == {YW{1'b0}}) begin
          if (WRAP != 0) next_y_s = YW'(ROWS - 1);
          else           blocked_s = 1'b1;
        end else begin
          next_y_s = cursor_y - YW'(1);
        end
      end
      2'b01: begin
        if (cursor_y >= YW'(ROWS - 1)) begin
          if (WRAP != 0) next_y_s = {YW{1'b0}};
          else           blocked_s = 1'b1;
        end else begin
          next_y_s = cursor_y + YW'(1);
        end
      end
      2'b10: begin
        if (cursor_x == {XW{1'b0}}) begin
          if (WRAP != 0) next_x_s = XW'(COLS - 1);
          else           blocked_s = 1'b1;
        end else begin
          next_x_s = cursor_x - XW'(1);
        end
      end
      2'b11: begin
        if (cursor_x >= XW'(COLS - 1)) begin
          if (WRAP != 0) next_x_s = {XW{1'b0}};
          else           blocked_s = 1'b1;
        end else begin
          next_x_s = cursor_x + XW'(1);
        end
      end
      default: begin
        next_x_s  = cursor_x;
        next_y_s  = cursor_y;
        blocked_s = 1'b0;
      end
    endcase
  end

  // Key tracking, repeat FSM, cursor and pulse registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r      <= ST_IDLE;
      held_code_r  <= 9'd0;
      cnt_r        <= {CW{1'b0}};
      cursor_x     <= {XW{1'b0}};
      cursor_y     <= {YW{1'b0}};
      sel_pulse    <= 1'b0;
      aux_pulse    <= 1'b0;
      cancel_pulse <= 1'b0;
      move_pulse   <= 1'b0;
      bump_pulse   <= 1'b0;
    end else begin
      sel_pulse    <= new_make_s & (code_s == CODE_SPACE);
      aux_pulse    <= new_make_s & (code_s == CODE_G);
      cancel_pulse <= new_make_s & (code_s == CODE_ESC);
      move_pulse   <= step_s & ~blocked_s;
      bump_pulse   <= step_s &  blocked_s;

      if (step_s && !blocked_s) begin
        cursor_x <= next_x_s;
        cursor_y <= next_y_s;
      end else begin
        cursor_x <= cursor_x;
        cursor_y <= cursor_y;
      end

      if (new_make_s) begin
        held_code_r <= code_s;
        cnt_r       <= {CW{1'b0}};
        if (make_dir_s[2] && (REPEAT_EN != 0)) state_r <= ST_DELAY;
        else                                   state_r <= ST_IDLE;
      end else if (held_break_s) begin
        held_code_r <= 9'd0;
        cnt_r       <= {CW{1'b0}};
        state_r     <= ST_IDLE;
      end else begin
        case (state_r)
          ST_IDLE: begin
            cnt_r <= {CW{1'b0}};
          end
          ST_DELAY: begin
            if (cnt_r == CW'(REP_DELAY - 1)) begin
              cnt_r   <= {CW{1'b0}};
              state_r <= ST_REPEAT;
            end else begin
              cnt_r <= cnt_r + CW'(1);
            end
          end
          ST_REPEAT: begin
            if (cnt_r == CW'(REP_PERIOD - 1)) cnt_r <= {CW{1'b0}};
            else                              cnt_r <= cnt_r + CW'(1);
          end
          default: begin
            cnt_r   <= {CW{1'b0}};
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_key_cursor_ctrl.sv
// Scoreboard bench for key_cursor_ctrl: a wrapping instance (dut0) and a
// clamping instance (dut1), both 5x8 with REP_DELAY=10, REP_PERIOD=4.
// Stimulus pushes expected pulse events (cycle, pulses, cursor) into a
// per-instance queue; a monitor pops and compares whenever a pulse appears.
module tb_key_cursor_ctrl;

  logic        clk;
  logic        rstn;
  logic [10:0] ke0, ke1;
  logic [2:0]  x0, y0, x1, y1;
  logic        sel0, aux0, can0, mov0, bmp0;
  logic        sel1, aux1, can1, mov1, bmp1;
  logic [4:0]  p0, p1;

  assign p0 = {sel0, aux0, can0, mov0, bmp0};
  assign p1 = {sel1, aux1, can1, mov1, bmp1};

  localparam logic [4:0] P_SEL = 5'b10000;
  localparam logic [4:0] P_AUX = 5'b01000;
  localparam logic [4:0] P_CAN = 5'b00100;
  localparam logic [4:0] P_MOV = 5'b00010;
  localparam logic [4:0] P_BMP = 5'b00001;

  key_cursor_ctrl #(.COLS(5), .ROWS(8), .XW(3), .YW(3), .WRAP(1), .REPEAT_EN(1),
                    .REP_DELAY(10), .REP_PERIOD(4), .CW(8)) dut0 (
    .clk(clk), .rstn(rstn), .key_event(ke0), .cursor_x(x0), .cursor_y(y0),
    .sel_pulse(sel0), .aux_pulse(aux0), .cancel_pulse(can0),
    .move_pulse(mov0), .bump_pulse(bmp0));

  key_cursor_ctrl #(.COLS(5), .ROWS(8), .XW(3), .YW(3), .WRAP(0), .REPEAT_EN(1),
                    .REP_DELAY(10), .REP_PERIOD(4), .CW(8)) dut1 (
    .clk(clk), .rstn(rstn), .key_event(ke1), .cursor_x(x1), .cursor_y(y1),
    .sel_pulse(sel1), .aux_pulse(aux1), .cancel_pulse(can1),
    .move_pulse(mov1), .bump_pulse(bmp1));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [4:0] p;
    logic [2:0] x;
    logic [2:0] y;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [10:0] mk(input logic [8:0] c);
    return {1'b1, c[8], 1'b0, c[7:0]};
  endfunction

  function automatic logic [10:0] bk(input logic [8:0] c);
    return {1'b1, c[8], 1'b1, c[7:0]};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expect an output event 'off' cycles after the event sampled at the next edge.
  task automatic push(input int i, input int off, input logic [4:0] p,
                      input logic [2:0] x, input logic [2:0] y);
    exp_t e;
    e.cyc = cyc + 1 + off;
    e.p   = p;
    e.x   = x;
    e.y   = y;
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic ev(input int i, input logic [10:0] v, input int n);
    if (i == 0) ke0 = v;
    else        ke1 = v;
    tick(n);
    if (i == 0) ke0 = 11'd0;
    else        ke1 = 11'd0;
  endtask

  task automatic chk(input string name, input logic [10:0] got, input logic [10:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic mon(input int i, input logic [4:0] p, input logic [2:0] x, input logic [2:0] y);
    exp_t e;
    int   sz;
    sz = (i == 0) ? q0.size() : q1.size();
    while (sz > 0) begin
      e = (i == 0) ? q0[0] : q1[0];
      if (e.cyc >= cyc) break;
      n_vec++;
      n_err++;
      $display("FAIL missed_event inst%0d: nothing seen, expected pulses %b (%0d,%0d) at cycle %0d",
               i, e.p, e.x, e.y, e.cyc);
      if (i == 0) void'(q0.pop_front());
      else        void'(q1.pop_front());
      sz--;
    end
    if (p != 5'b00000) begin
      n_vec++;
      if (sz > 0 && e.cyc == cyc) begin
        if (i == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
        if (p !== e.p || x !== e.x || y !== e.y) begin
          n_err++;
          $display("FAIL event inst%0d cycle %0d: got pulses %b (%0d,%0d) expected pulses %b (%0d,%0d)",
                   i, cyc, p, x, y, e.p, e.x, e.y);
        end
      end else begin
        n_err++;
        $display("FAIL unexpected_event inst%0d cycle %0d: got pulses %b (%0d,%0d) expected none",
                 i, cyc, p, x, y);
      end
    end
  endtask

  // Monitor: compares every presented pulse against the scoreboard.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rstn) begin
        mon(0, p0, x0, y0);
        mon(1, p1, x1, y1);
      end
    end
  end

  // Decode table: code, then expected cursor after one step (wrap instance).
  logic [14:0] tbl [9] = '{
    {9'h16B, 3'd3, 3'd1}, {9'h03B, 3'd2, 3'd1}, {9'h043, 3'd2, 3'd0},
    {9'h175, 3'd2, 3'd7}, {9'h01B, 3'd2, 3'd0}, {9'h042, 3'd2, 3'd1},
    {9'h023, 3'd3, 3'd1}, {9'h174, 3'd4, 3'd1}, {9'h01D, 3'd4, 3'd0}
  };

  initial begin : stim
    logic [14:0] row;
    clk  = 1'b0;
    rstn = 1'b0;
    ke0  = 11'd0;
    ke1  = 11'd0;
    #3;
    chk("reset_dut0", {p0, x0, y0}, 11'd0);
    chk("reset_dut1", {p1, x1, y1}, 11'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    tick(2);

    // Clamp instance: edges bump, interior moves, held Up bumps again on repeat.
    push(1, 0, P_BMP, 3'd0, 3'd0); ev(1, mk(9'h01D), 1); ev(1, bk(9'h01D), 1); tick(2);
    push(1, 0, P_BMP, 3'd0, 3'd0); ev(1, mk(9'h01C), 1); ev(1, bk(9'h01C), 1); tick(2);
    push(1, 0, P_MOV, 3'd1, 3'd0); ev(1, mk(9'h023), 1); ev(1, bk(9'h023), 1); tick(2);
    push(1, 0, P_MOV, 3'd0, 3'd0); ev(1, mk(9'h01C), 1); ev(1, bk(9'h01C), 1); tick(2);
    push(1, 0, P_BMP, 3'd0, 3'd0);
    push(1, 10, P_BMP, 3'd0, 3'd0);
    ev(1, mk(9'h01D), 1); tick(10); ev(1, bk(9'h01D), 1); tick(10);

    // Left held valid 3 cycles from (0,0): one move, wraps to x=4.
    push(0, 0, P_MOV, 3'd4, 3'd0); ev(0, mk(9'h01C), 3); ev(0, bk(9'h01C), 1); tick(5);

    // Break arriving in the same cycle as the first repeat step wins.
    push(0, 0, P_MOV, 3'd0, 3'd0); ev(0, mk(9'h023), 1); tick(9); ev(0, bk(9'h023), 1); tick(20);

    // Held Right (L): steps at +1, +11, +15, +19; break afterwards stops it.
    push(0, 0,  P_MOV, 3'd1, 3'd0);
    push(0, 10, P_MOV, 3'd2, 3'd0);
    push(0, 14, P_MOV, 3'd3, 3'd0);
    push(0, 18, P_MOV, 3'd4, 3'd0);
    ev(0, mk(9'h04B), 1); tick(18); ev(0, bk(9'h04B), 1); tick(25);

    // Space press/break/re-press, then a 5-cycle level; Esc held 3 cycles.
    push(0, 0, P_SEL, 3'd4, 3'd0); ev(0, mk(9'h029), 1); tick(1); ev(0, bk(9'h029), 1); tick(1);
    push(0, 0, P_SEL, 3'd4, 3'd0); ev(0, mk(9'h029), 1); tick(1); ev(0, bk(9'h029), 1); tick(1);
    push(0, 0, P_SEL, 3'd4, 3'd0); ev(0, mk(9'h029), 5); ev(0, bk(9'h029), 1); tick(2);
    push(0, 0, P_CAN, 3'd4, 3'd0); ev(0, mk(9'h076), 3); ev(0, bk(9'h076), 1); tick(2);

    // E0 Down moves; plain 0_72 is not a direction.
    push(0, 0, P_MOV, 3'd4, 3'd1); ev(0, mk(9'h172), 1); ev(0, bk(9'h172), 1); tick(2);
    ev(0, mk(9'h072), 2); ev(0, bk(9'h072), 1); tick(15);

    // Remaining direction codes, including row wrap both ways.
    for (int k = 0; k < 9; k++) begin
      row = tbl[k];
      push(0, 0, P_MOV, row[5:3], row[2:0]);
      ev(0, mk(row[14:6]), 1); ev(0, bk(row[14:6]), 1); tick(1);
    end

    // Up held into REPEAT, then G: aux pulse and no further steps.
    push(0, 0,  P_MOV, 3'd4, 3'd7);
    push(0, 10, P_MOV, 3'd4, 3'd6);
    ev(0, mk(9'h01D), 1); tick(10);
    push(0, 0, P_AUX, 3'd4, 3'd6); ev(0, mk(9'h034), 1); tick(20);
    ev(0, bk(9'h034), 1); tick(2);

    // Reset pulse mid-DELAY: cursor back to origin and no repeat step.
    push(0, 0, P_MOV, 3'd3, 3'd6); ev(0, mk(9'h01C), 1); tick(3);
    rstn = 1'b0;
    #1;
    chk("async_reset_dut0", {p0, x0, y0}, 11'd0);
    chk("async_reset_dut1", {p1, x1, y1}, 11'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
    tick(30);
    chk("post_reset_cursor", {5'd0, x0, y0}, 11'd0);

    tick(3);
    chk("scoreboard_empty_dut0", 11'(q0.size()), 11'd0);
    chk("scoreboard_empty_dut1", 11'(q1.size()), 11'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
